clock_generator: RTL and testbench
==================================

Name: clock_generator

Overview:
- Synthesizable programmable clock divider that derives the pipeline's slow system clock `clock` from the reference clock `clk`.
- Single clock domain; output is a registered, glitch-free divided clock plus a one-cycle period-start strobe.
- Division ratio can change at run time, but a change only takes effect at a period boundary.
- Default ratio 2: 10-time-unit clk period gives a 20-unit `clock` period (high 10, low 10).

Parameters:
- DIV_WIDTH, 8, width of the division-ratio fields.
- DEFAULT_DIV, 2, division ratio loaded at reset; must be ≥2 and fit in DIV_WIDTH.

Ports:
- clk  input  1  reference clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  run request; 1 = generate clock, 0 = stop at end of current period.
- div_in  input  DIV_WIDTH  requested division ratio N.
- load  input  1  when 1 on a clk edge, div_in is captured into the pending-ratio register.
- clock  output  1  divided clock, registered.
- tick  output  1  one-clk-cycle pulse, coincident with each rising edge of `clock`.
- running  output  1  1 while a `clock` period is in progress.
- div_active  output  DIV_WIDTH  ratio currently in effect.

Behaviour:
- Reset (reset=1 at clk edge, overrides everything):
  - clock=0, tick=0, running=0, cnt=0.
  - div_active=DEFAULT_DIV, pending=DEFAULT_DIV.
  - Generator enters the idle state.
- Ratio clamp: the effective N is max(div_active, 2); div values 0 and 1 behave as 2.
- High-phase length: H = (N+1)>>1.
  - Odd N gives the extra cycle to the high phase.
  - Examples: N=2 → 1 high/1 low; N=3 → 2/1; N=5 → 3/2.
- Period start: occurs on an edge where either
  - the generator is idle and enable=1, or
  - running=1 and cnt==N-1 and enable=1.
- At a period start:
  - div_active<=pending (new N used for this period).
  - cnt<=0, clock<=1, tick<=1, running<=1.
- Within a period (running=1, cnt<N-1):
  - cnt<=cnt+1.
  - clock<=(cnt+1 < H).
  - tick<=0.
- End of period with enable=0 (running=1, cnt==N-1):
  - clock<=0, running<=0, tick<=0; enter idle.
  - No truncated pulses: enable falling mid-period never shortens the current period.
- Idle with enable=0: all outputs hold 0 except div_active.
- Load timing:
  - load=1 updates pending on that same edge.
  - If that edge is also a period start, the new value takes effect immediately (pending is written before the transfer).
  - Otherwise the new value takes effect at the next period start.
  - Multiple loads within one period: last one wins.
- Latency: enable 0→1 while idle gives clock=1 and tick=1 on the first clk edge that samples enable=1.
- Reset asserted mid-period: outputs return to reset values on that edge, with no completion of the period.

Optional Feature:
- Macro: CLKGEN_PERIOD_COUNT_EN.
- Defined:
  - Adds output period_count, 32 bits.
  - Increments by 1 at every period start; wraps 0xFFFFFFFF→0.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then enable=1 with DEFAULT_DIV=2 → clock toggles every clk edge (1,0,1,0…); tick=1 on each high edge; period = 2 clk cycles.
- load=1, div_in=5 mid-period (N=2) → current period finishes at N=2; following periods are 3 clk high, 2 low; div_active reads 5 from that period start.
- div_in=0 and div_in=1 loaded → behaves exactly as N=2; div_active still reports the raw loaded value.
- N=4 running, enable dropped at cnt=1 → clock completes remaining low cycles (cnt 2,3), then holds 0, running=0; re-enable → clock=1 and tick=1 on the next edge.
- Reset asserted at cnt=2 of an N=5 period → next edge gives clock=0, running=0, div_active=2, cnt=0; idle until enable is sampled high.
- With CLKGEN_PERIOD_COUNT_EN defined and N=3, 10 periods run → period_count=10; reset → 0.

Source files
------------

// File: rtl/clock_generator.sv
// Programmable clock divider: derives a registered, glitch-free `clock` and a period-start
// `tick` from `clk`. Optional macro CLKGEN_PERIOD_COUNT_EN adds a 32-bit period counter.
module clock_generator #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 load,
  output logic                 clock,
  output logic                 tick,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] div_active
`ifdef CLKGEN_PERIOD_COUNT_EN
  ,
  output logic [31:0]          period_count
`endif
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [DIV_WIDTH-1:0] DEFAULT_VAL = DEFAULT_DIV[DIV_WIDTH-1:0];
  localparam logic [DIV_WIDTH-1:0] ONE         = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] TWO         = {{(DIV_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [DIV_WIDTH:0]   ONE_W       = {{DIV_WIDTH{1'b0}}, 1'b1};

  state_t                 state_reg, state_next;
  logic [DIV_WIDTH-1:0]   cnt_reg, cnt_next;
  logic                   clock_reg, clock_next;
  logic                   tick_reg, tick_next;
  logic [DIV_WIDTH-1:0]   div_active_reg, div_active_next;
  logic [DIV_WIDTH-1:0]   pending_reg, pending_next;

  logic [DIV_WIDTH-1:0]   n_eff;
  logic [DIV_WIDTH-1:0]   last_cnt;
  logic [DIV_WIDTH:0]     high_len;
  logic [DIV_WIDTH:0]     cnt_inc;
  logic                   at_last;
  logic                   period_start;

  // Ratios 0 and 1 are treated as 2; the extra cycle of an odd ratio goes high.
  always_comb begin
    n_eff        = (div_active_reg < TWO) ? TWO : div_active_reg;
    last_cnt     = n_eff - ONE;
    high_len     = ({1'b0, n_eff} + ONE_W) >> 1;
    cnt_inc      = {1'b0, cnt_reg} + ONE_W;
    at_last      = (cnt_reg == last_cnt);
    period_start = enable && ((state_reg == ST_IDLE) || at_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      clock_reg      <= 1'b0;
      tick_reg       <= 1'b0;
      div_active_reg <= DEFAULT_VAL;
      pending_reg    <= DEFAULT_VAL;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      clock_reg      <= clock_next;
      tick_reg       <= tick_next;
      div_active_reg <= div_active_next;
      pending_reg    <= pending_next;
    end
  end

  // A load on a period-start edge bypasses the pending register so it applies at once.
  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    clock_next      = clock_reg;
    tick_next       = 1'b0;
    div_active_next = div_active_reg;
    pending_next    = load ? div_in : pending_reg;

    if (period_start) begin
      state_next      = ST_RUN;
      cnt_next        = '0;
      clock_next      = 1'b1;
      tick_next       = 1'b1;
      div_active_next = pending_next;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_next   = '0;
          clock_next = 1'b0;
        end
        ST_RUN: begin
          if (at_last) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            clock_next = 1'b0;
          end else begin
            cnt_next   = cnt_inc[DIV_WIDTH-1:0];
            clock_next = (cnt_inc < high_len);
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          clock_next = 1'b0;
        end
      endcase
    end
  end

`ifdef CLKGEN_PERIOD_COUNT_EN
  logic [31:0] period_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      period_count_reg <= 32'd0;
    end else if (period_start) begin
      period_count_reg <= period_count_reg + 32'd1;
    end
  end

  assign period_count = period_count_reg;
`endif

  assign clock      = clock_reg;
  assign tick       = tick_reg;
  assign running    = (state_reg == ST_RUN);
  assign div_active = div_active_reg;

endmodule

// File: tb/tb_clock_generator.sv
// Directed bench for clock_generator: expected {clock,tick,running,div_active} words are
// queued as each step is driven and popped/compared 1 time unit after the clk edge.
module tb_clock_generator;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [DW-1:0] div_in;
  logic          load;
  logic          clock;
  logic          tick;
  logic          running;
  logic [DW-1:0] div_active;
`ifdef CLKGEN_PERIOD_COUNT_EN
  logic [31:0]   period_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW+2:0] exp_q[$];
  string         tag_q[$];

  always #5 clk = ~clk;

  clock_generator #(.DIV_WIDTH(DW), .DEFAULT_DIV(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .div_in     (div_in),
    .load       (load),
    .clock      (clock),
    .tick       (tick),
    .running    (running),
    .div_active (div_active)
`ifdef CLKGEN_PERIOD_COUNT_EN
    ,
    .period_count (period_count)
`endif
  );

  // Drive one edge worth of inputs, queue the expected outputs, then check them after the edge.
  task automatic step(input string tag, input logic rst, input logic en, input logic ld,
                      input logic [DW-1:0] din, input logic e_clock, input logic e_tick,
                      input logic e_run, input logic [DW-1:0] e_div);
    logic [DW+2:0] obs;
    logic [DW+2:0] exp;
    string         t;
    @(negedge clk);
    reset  = rst;
    enable = en;
    load   = ld;
    div_in = din;
    exp_q.push_back({e_clock, e_tick, e_run, e_div});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    t   = tag_q.pop_front();
    obs = {clock, tick, running, div_active};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed clk/tick/run/div=%b/%b/%b/%0d expected %b/%b/%b/%0d",
             t, obs[DW+2], obs[DW+1], obs[DW], obs[DW-1:0],
             exp[DW+2], exp[DW+1], exp[DW], exp[DW-1:0]);
    end
    $display("step %-12s clock=%b tick=%b running=%b div_active=%0d", t, clock, tick, running, div_active);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; div_in = '0;

    // reset and idle
    step("reset0",    1, 0, 0, 8'd0, 0, 0, 0, 8'd2);
    step("reset1",    1, 1, 1, 8'd9, 0, 0, 0, 8'd2);
    step("idle",      0, 0, 0, 8'd0, 0, 0, 0, 8'd2);

    // default N=2 toggling
    step("n2_start0", 0, 1, 0, 8'd0, 1, 1, 1, 8'd2);
    step("n2_low0",   0, 1, 0, 8'd0, 0, 0, 1, 8'd2);
    step("n2_start1", 0, 1, 0, 8'd0, 1, 1, 1, 8'd2);
    step("n2_low1",   0, 1, 0, 8'd0, 0, 0, 1, 8'd2);
    step("n2_start2", 0, 1, 0, 8'd0, 1, 1, 1, 8'd2);

    // load 5 mid-period: current N=2 period finishes unchanged
    step("ld5_mid",   0, 1, 1, 8'd5, 0, 0, 1, 8'd2);
    step("n5_c0",     0, 1, 0, 8'd0, 1, 1, 1, 8'd5);
    step("n5_c1",     0, 1, 0, 8'd0, 1, 0, 1, 8'd5);
    step("n5_c2",     0, 1, 0, 8'd0, 1, 0, 1, 8'd5);
    step("n5_c3",     0, 1, 0, 8'd0, 0, 0, 1, 8'd5);
    step("n5_c4",     0, 1, 0, 8'd0, 0, 0, 1, 8'd5);
    step("n5_p2c0",   0, 1, 0, 8'd0, 1, 1, 1, 8'd5);

    // load 0 in the middle (last wins: 7 then 0), then behaves as N=2
    step("ld7_c1",    0, 1, 1, 8'd7, 1, 0, 1, 8'd5);
    step("ld0_c2",    0, 1, 1, 8'd0, 1, 0, 1, 8'd5);
    step("n5_p2c3",   0, 1, 0, 8'd0, 0, 0, 1, 8'd5);
    step("n5_p2c4",   0, 1, 0, 8'd0, 0, 0, 1, 8'd5);
    step("n0_start",  0, 1, 0, 8'd0, 1, 1, 1, 8'd0);
    step("n0_low",    0, 1, 0, 8'd0, 0, 0, 1, 8'd0);

    // load on a period-start edge applies immediately
    step("ld1_start", 0, 1, 1, 8'd1, 1, 1, 1, 8'd1);
    step("n1_low",    0, 1, 0, 8'd0, 0, 0, 1, 8'd1);
    step("ld4_start", 0, 1, 1, 8'd4, 1, 1, 1, 8'd4);

    // N=4, enable dropped while cnt=1: period completes, then idles
    step("n4_c1",     0, 1, 0, 8'd0, 1, 0, 1, 8'd4);
    step("n4_dis_c2", 0, 0, 0, 8'd0, 0, 0, 1, 8'd4);
    step("n4_dis_c3", 0, 0, 0, 8'd0, 0, 0, 1, 8'd4);
    step("n4_stop",   0, 0, 0, 8'd0, 0, 0, 0, 8'd4);
    step("n4_idle",   0, 0, 0, 8'd0, 0, 0, 0, 8'd4);
    step("n4_reen",   0, 1, 0, 8'd0, 1, 1, 1, 8'd4);

    // reset at cnt=2 of an N=5 period
    step("ld5_n4c1",  0, 1, 1, 8'd5, 1, 0, 1, 8'd4);
    step("n4_c2",     0, 1, 0, 8'd0, 0, 0, 1, 8'd4);
    step("n4_c3",     0, 1, 0, 8'd0, 0, 0, 1, 8'd4);
    step("r5_c0",     0, 1, 0, 8'd0, 1, 1, 1, 8'd5);
    step("r5_c1",     0, 1, 0, 8'd0, 1, 0, 1, 8'd5);
    step("r5_c2",     0, 1, 0, 8'd0, 1, 0, 1, 8'd5);
    step("rst_mid",   1, 1, 0, 8'd0, 0, 0, 0, 8'd2);
    step("rst_idle",  0, 0, 0, 8'd0, 0, 0, 0, 8'd2);
    step("rst_reen",  0, 1, 0, 8'd0, 1, 1, 1, 8'd2);
    step("rst_low",   0, 1, 0, 8'd0, 0, 0, 1, 8'd2);
    step("rst_next",  0, 1, 0, 8'd0, 1, 1, 1, 8'd2);

    // odd N=3: 2 high, 1 low
    step("ld3",       0, 1, 1, 8'd3, 0, 0, 1, 8'd2);
    step("n3_c0",     0, 1, 0, 8'd0, 1, 1, 1, 8'd3);
    step("n3_c1",     0, 1, 0, 8'd0, 1, 0, 1, 8'd3);
    step("n3_c2",     0, 1, 0, 8'd0, 0, 0, 1, 8'd3);
    step("n3_next",   0, 1, 0, 8'd0, 1, 1, 1, 8'd3);

`ifdef CLKGEN_PERIOD_COUNT_EN
    step("pc_reset",  1, 0, 0, 8'd0, 0, 0, 0, 8'd2);
    checks++;
    assert (period_count === 32'd0) else begin
      failures++;
      $error("FAIL pc_after_reset observed=%0d expected=0", period_count);
    end
    for (int i = 0; i < 30; i++) begin
      case (i % 3)
        0:       step("pc_n3_c0", 0, 1, (i == 0), 8'd3, 1, 1, 1, 8'd3);
        1:       step("pc_n3_c1", 0, 1, 0, 8'd0, 1, 0, 1, 8'd3);
        default: step("pc_n3_c2", 0, 1, 0, 8'd0, 0, 0, 1, 8'd3);
      endcase
    end
    checks++;
    assert (period_count === 32'd10) else begin
      failures++;
      $error("FAIL pc_ten observed=%0d expected=10", period_count);
    end
    step("pc_reset2", 1, 0, 0, 8'd0, 0, 0, 0, 8'd2);
    checks++;
    assert (period_count === 32'd0) else begin
      failures++;
      $error("FAIL pc_cleared observed=%0d expected=0", period_count);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
